// File: rtl/ro_freq_counter_pkg.sv
// ----------------------------------------------------------------------------
// ro_freq_counter_pkg
// Shared definitions for the ring-oscillator frequency counter:
//   - state_t    : measurement FSM states
//   - RO_NUM     : number of selectable oscillator inputs (X1_Y1..X5_Y1)
//   - CNT_W_DEF  : default width of the rising-edge counter
// ----------------------------------------------------------------------------
package ro_freq_counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int RO_NUM    = 5;
    localparam int CNT_W_DEF = 24;

endpackage

// File: rtl/ro_edge_sync.sv
// ----------------------------------------------------------------------------
// ro_edge_sync
// Brings one asynchronous oscillator output into the wb_clk_i domain through
// a SYNC_STG-deep flop chain, then flags each synchronized 0->1 transition
// with a one-cycle pulse using one extra history flop.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, clears every flop
//   din    : asynchronous oscillator level
//   rise   : one-cycle pulse per synchronized rising edge
// ----------------------------------------------------------------------------
module ro_edge_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    // Depths below two give no metastability protection, so clamp to two.
    localparam int STG = (SYNC_STG < 2) ? 2 : SYNC_STG;

    logic [STG-1:0] sync_q;
    logic           prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STG-2:0], din};
            prev_q <= sync_q[STG-1];
        end
    end

    assign rise = sync_q[STG-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// ----------------------------------------------------------------------------
// ro_freq_counter
// Measures one of five ring oscillators by counting its rising edges over a
// programmable window of wb_clk_i cycles. A request latches the oscillator
// index, stage-select code and window length; the oscillator is enabled,
// allowed to settle for SETTLE_CYC cycles, counted for gate_len cycles, and
// the result is published with a one-cycle count_vld pulse.
//
// Ports:
//   wb_clk_i, wb_rst_n      : system clock, async active-low reset
//   meas_req, abort         : start / cancel a measurement
//   ro_idx, sel_cfg,gate_len: oscillator select (0-4), stage code, window
//   s1..s5, start           : stage selects and oscillator enable
//   X1_Y1..X5_Y1            : asynchronous oscillator outputs
//   busy                    : FSM not idle
//   count, count_vld, ovf   : result, new-result pulse, saturation flag
// ----------------------------------------------------------------------------
module ro_freq_counter
    import ro_freq_counter_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int SETTLE_CYC = 16,
    parameter int SYNC_STG   = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             meas_req,
    input  logic             abort,
    input  logic [2:0]       ro_idx,
    input  logic [4:0]       sel_cfg,
    input  logic [15:0]      gate_len,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             s4,
    output logic             s5,
    output logic             start,
    input  logic             X1_Y1,
    input  logic             X2_Y1,
    input  logic             X3_Y1,
    input  logic             X4_Y1,
    input  logic             X5_Y1,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_vld,
    output logic             ovf
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t             state;
    state_t             state_n;
    logic [SET_W-1:0]   settle_cnt;
    logic [15:0]        gate_cnt;
    logic [2:0]         idx_q;
    logic [4:0]         sel_q;
    logic [15:0]        glen_q;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]   edge_next;
    logic               sat_q;
    logic               sat_next;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;
    logic               vld_q;
    logic               osc_sel;
    logic               osc_rise;
    logic               req_ok;
    logic               settle_last;
    logic               gate_last;

    // Select the latched oscillator before synchronizing so only one
    // synchronizer is needed; indices above four are never latched.
    always_comb begin
        osc_sel = 1'b0;
        case (idx_q)
            3'd0:    osc_sel = X1_Y1;
            3'd1:    osc_sel = X2_Y1;
            3'd2:    osc_sel = X3_Y1;
            3'd3:    osc_sel = X4_Y1;
            3'd4:    osc_sel = X5_Y1;
            default: osc_sel = 1'b0;
        endcase
    end

    ro_edge_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_edge_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .din   (osc_sel),
        .rise  (osc_rise)
    );

    assign req_ok      = meas_req && !abort && (ro_idx < 3'(RO_NUM));
    assign settle_last = (settle_cnt == SET_W'(SETTLE_CYC - 1));
    assign gate_last   = (gate_cnt == (glen_q - 16'd1));

    // Saturating increment: once all-ones, further edges only raise the
    // overflow flag so the reported count never wraps.
    always_comb begin
        edge_next = edge_cnt;
        sat_next  = sat_q;
        if (osc_rise) begin
            if (&edge_cnt) begin
                sat_next = 1'b1;
            end else begin
                edge_next = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. abort beats a simultaneous request in IDLE and
    // cancels SETTLE/GATE without passing through DONE. A zero-length
    // window skips GATE entirely.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (settle_last) begin
                    state_n = (glen_q == 16'd0) ? DONE : GATE;
                end
            end
            GATE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (gate_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath. The result registers load on the edge that enters DONE,
    // including any edge arriving in the final GATE cycle, so count and
    // count_vld are valid together during DONE.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            settle_cnt <= '0;
            gate_cnt   <= '0;
            idx_q      <= '0;
            sel_q      <= '0;
            glen_q     <= '0;
            edge_cnt   <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_n == SETTLE) begin
                        idx_q      <= ro_idx;
                        sel_q      <= sel_cfg;
                        glen_q     <= gate_len;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    if (state_n == GATE) begin
                        edge_cnt <= '0;
                        sat_q    <= 1'b0;
                        gate_cnt <= '0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + 16'd1;
                    edge_cnt <= edge_next;
                    sat_q    <= sat_next;
                end
                default: begin
                end
            endcase
            if ((state_n == DONE) && (state != DONE)) begin
                vld_q   <= 1'b1;
                count_q <= (state == GATE) ? edge_next : '0;
                ovf_q   <= (state == GATE) && sat_next;
            end
        end
    end

    assign start     = (state == SETTLE) || (state == GATE);
    assign busy      = (state != IDLE);
    assign s1        = sel_q[0];
    assign s2        = sel_q[1];
    assign s3        = sel_q[2];
    assign s4        = sel_q[3];
    assign s5        = sel_q[4];
    assign count     = count_q;
    assign count_vld = vld_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// ----------------------------------------------------------------------------
// tb_ro_freq_counter
// Drives two counters (default width and a 4-bit one) from the same stimulus.
// Oscillator levels change on the falling clock edge and every level seen at
// a rising edge is logged; expected counts are the number of logged 0->1
// steps of the chosen oscillator inside the counting window.
// ----------------------------------------------------------------------------
module tb_ro_freq_counter;

    localparam int SETTLE = 16;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        meas_req = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  ro_idx = '0;
    logic [4:0]  sel_cfg = '0;
    logic [15:0] gate_len = '0;
    logic [4:0]  xv = '0;

    logic        s1_a, s2_a, s3_a, s4_a, s5_a, start_a, busy_a, vld_a, ovf_a;
    logic [23:0] count_a;
    logic        s1_b, s2_b, s3_b, s4_b, s5_b, start_b, busy_b, vld_b, ovf_b;
    logic [3:0]  count_b;

    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    logic [4:0]  hist [0:65535];
    int          wave_line = 0;
    int          wmode = 0;
    int          phase = 0;
    int          lc_a = 0;
    int          lo_a = 0;
    int          lc_b = 0;
    int          lo_b = 0;
    logic [4:0]  last_cfg = '0;

    always #5 clk = ~clk;

    ro_freq_counter dut (
        .wb_clk_i (clk), .wb_rst_n (rst_n), .meas_req (meas_req), .abort (abort),
        .ro_idx (ro_idx), .sel_cfg (sel_cfg), .gate_len (gate_len),
        .s1 (s1_a), .s2 (s2_a), .s3 (s3_a), .s4 (s4_a), .s5 (s5_a), .start (start_a),
        .X1_Y1 (xv[0]), .X2_Y1 (xv[1]), .X3_Y1 (xv[2]), .X4_Y1 (xv[3]), .X5_Y1 (xv[4]),
        .busy (busy_a), .count (count_a), .count_vld (vld_a), .ovf (ovf_a)
    );

    ro_freq_counter #(.CNT_W (4)) dut4 (
        .wb_clk_i (clk), .wb_rst_n (rst_n), .meas_req (meas_req), .abort (abort),
        .ro_idx (ro_idx), .sel_cfg (sel_cfg), .gate_len (gate_len),
        .s1 (s1_b), .s2 (s2_b), .s3 (s3_b), .s4 (s4_b), .s5 (s5_b), .start (start_b),
        .X1_Y1 (xv[0]), .X2_Y1 (xv[1]), .X3_Y1 (xv[2]), .X4_Y1 (xv[3]), .X5_Y1 (xv[4]),
        .busy (busy_b), .count (count_b), .count_vld (vld_b), .ovf (ovf_b)
    );

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on disagreement counts a failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: log oscillator levels at the rising edge, then move
    // to the falling edge and drive the next oscillator levels.
    task automatic applyStimulus();
        @(posedge clk);
        cyc++;
        hist[cyc] = xv;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == wave_line && wmode != 0)
                xv[i] = (((cyc + phase) % wmode) < (wmode / 2));
            else
                xv[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Rising steps of oscillator idx whose synchronized pulse lands on a
    // GATE clock of a request accepted at edge a.
    function automatic int modelEdges(input int a, input int idx, input int g);
        int e = 0;
        for (int j = a + SETTLE + 1 - SYNC; j <= a + SETTLE + g - SYNC; j++)
            if (hist[j][idx] && !hist[j-1][idx]) e++;
        return e;
    endfunction

    task automatic checkIdleHold(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy_a), 32'd0);
        checkOutput({tag, "_start"}, 32'(start_a), 32'd0);
        checkOutput({tag, "_vld"}, 32'(vld_a), 32'd0);
        checkOutput({tag, "_count"}, 32'(count_a), 32'(lc_a));
        checkOutput({tag, "_ovf"}, 32'(ovf_a), 32'(lo_a));
        checkOutput({tag, "_s"}, 32'({s5_a, s4_a, s3_a, s2_a, s1_a}), 32'(last_cfg));
        checkOutput({tag, "_count4"}, 32'(count_b), 32'(lc_b));
    endtask

    // Full measurement. abort_at / busy_req_at give the cycle offset after
    // acceptance at which to abort or to issue a competing request (-1: none).
    task automatic measure(input string tag, input int idx, input logic [4:0] cfg,
                           input int g, input int period, input int abort_at,
                           input int busy_req_at);
        int a;
        int e;
        int cnt_start = 0;
        wave_line = idx;
        wmode = period;
        phase = $urandom_range(0, 7);
        meas_req = 1'b1; ro_idx = 3'(idx); sel_cfg = cfg; gate_len = 16'(g);
        applyStimulus();
        a = cyc;
        meas_req = 1'b0;
        ro_idx = 3'($urandom); sel_cfg = 5'($urandom); gate_len = 16'($urandom);
        for (int off = 0; off < SETTLE + g; off++) begin
            if (off == abort_at) begin
                abort = 1'b1;
                applyStimulus();
                abort = 1'b0;
                checkOutput({tag, "_abort_start"}, 32'(start_a), 32'd0);
                last_cfg = cfg;
                checkIdleHold({tag, "_abort"});
                for (int k = 0; k < SETTLE + g; k++) begin
                    applyStimulus();
                    checkOutput({tag, "_abort_novld"}, 32'(vld_a | vld_b), 32'd0);
                end
                return;
            end
            if (start_a) cnt_start++;
            checkOutput({tag, "_busy"}, 32'(busy_a), 32'd1);
            checkOutput({tag, "_vld_low"}, 32'(vld_a), 32'd0);
            checkOutput({tag, "_s"}, 32'({s5_a, s4_a, s3_a, s2_a, s1_a}), 32'(cfg));
            if (off == busy_req_at) begin
                meas_req = 1'b1;
                ro_idx = 3'((idx + 1) % 5);
                sel_cfg = ~cfg;
                gate_len = 16'(g + 7);
            end
            applyStimulus();
            meas_req = 1'b0;
        end
        e = modelEdges(a, idx, g);
        checkOutput({tag, "_start_cycles"}, 32'(cnt_start), 32'(SETTLE + g));
        checkOutput({tag, "_done_start"}, 32'(start_a), 32'd0);
        checkOutput({tag, "_done_busy"}, 32'(busy_a), 32'd1);
        checkOutput({tag, "_done_vld"}, 32'(vld_a), 32'd1);
        checkOutput({tag, "_count"}, 32'(count_a), 32'(e));
        checkOutput({tag, "_ovf"}, 32'(ovf_a), 32'd0);
        checkOutput({tag, "_vld4"}, 32'(vld_b), 32'd1);
        checkOutput({tag, "_count4"}, 32'(count_b), 32'((e > 15) ? 15 : e));
        checkOutput({tag, "_ovf4"}, 32'(ovf_b), 32'(e > 15));
        lc_a = e; lo_a = 0;
        lc_b = (e > 15) ? 15 : e; lo_b = (e > 15) ? 1 : 0;
        last_cfg = cfg;
        applyStimulus();
        checkIdleHold({tag, "_after"});
    endtask

    initial begin
        int g;
        int per;
        $display("[TB] start");
        repeat (3) applyStimulus();
        checkOutput("reset_start", 32'(start_a), 32'd0);
        checkOutput("reset_busy", 32'(busy_a), 32'd0);
        checkOutput("reset_count", 32'(count_a), 32'd0);
        checkOutput("reset_vld", 32'(vld_a), 32'd0);
        checkOutput("reset_ovf", 32'(ovf_a), 32'd0);
        checkOutput("reset_s", 32'({s5_a, s4_a, s3_a, s2_a, s1_a}), 32'd0);
        rst_n = 1'b1;
        applyStimulus();
        checkIdleHold("post_reset");

        // zero-length window
        measure("gate0", 1, 5'b01101, 0, 0, -1, -1);

        // ro_idx 2 at f/8 over 100 cycles
        measure("f8", 2, 5'b10101, 100, 8, -1, -1);
        checkOutput("f8_range", 32'(lc_a == 12 || lc_a == 13), 32'd1);

        // 4-bit instance saturates at f/4 over 200 cycles
        measure("sat", 3, 5'b00111, 200, 4, -1, -1);
        checkOutput("sat_ovf4", 32'(ovf_b), 32'd1);
        checkOutput("sat_count4", 32'(count_b), 32'hF);

        // out-of-range index and request+abort in IDLE are both dropped
        meas_req = 1'b1; ro_idx = 3'd6; sel_cfg = 5'b11111; gate_len = 16'd5;
        applyStimulus();
        meas_req = 1'b0;
        checkIdleHold("idx6");
        meas_req = 1'b1; abort = 1'b1; ro_idx = 3'd0; sel_cfg = 5'b11110;
        applyStimulus();
        meas_req = 1'b0; abort = 1'b0;
        checkIdleHold("req_abort");

        // competing request while busy is ignored
        measure("busyreq", 4, 5'b10010, 40, 6, -1, 20);

        // abort on the fifth GATE cycle keeps the previous result
        measure("abort", 0, 5'b01010, 60, 0, SETTLE + 5, -1);

        // randomized measurements
        for (int n = 0; n < 10; n++) begin
            g = $urandom_range(1, 60);
            per = $urandom_range(0, 3);
            per = (per == 0) ? 0 : per * 2 + 1;
            measure("rand", $urandom_range(0, 4), 5'($urandom), g, per, -1, -1);
        end

        // reset in the middle of GATE
        wave_line = 2; wmode = 0;
        meas_req = 1'b1; ro_idx = 3'd2; sel_cfg = 5'b11011; gate_len = 16'd50;
        applyStimulus();
        meas_req = 1'b0;
        repeat (SETTLE + 10) applyStimulus();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_start", 32'(start_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_count", 32'(count_a), 32'd0);
        checkOutput("rst_vld", 32'(vld_a), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_a), 32'd0);
        checkOutput("rst_s", 32'({s5_a, s4_a, s3_a, s2_a, s1_a}), 32'd0);
        checkOutput("rst_count4", 32'({ovf_b, count_b}), 32'd0);
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        lc_a = 0; lo_a = 0; lc_b = 0; lo_b = 0; last_cfg = '0;
        for (int k = 0; k < 60; k++) begin
            applyStimulus();
            checkOutput("rst_novld", 32'(vld_a | busy_a), 32'd0);
        end
        measure("after_rst", 2, 5'b00001, 30, 8, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 24, giving the edge-count width.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 16, giving the clocks between start assertion and gate open.
REQ-003 The block SHALL have parameter SYNC_STG, default 2, giving the synchronizer depth for oscillator inputs (minimum 2).
REQ-004 Port wb_clk_i, input, 1 bit: the single system clock.
REQ-005 Port wb_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port meas_req, input, 1 bit: single-cycle request to start a measurement.
REQ-007 Port abort, input, 1 bit: cancels a measurement in progress.
REQ-008 Port ro_idx, input, 3 bits: oscillator to measure, valid values 0-4 select X1_Y1..X5_Y1.
REQ-009 Port sel_cfg, input, 5 bits: stage-select code driven onto s1..s5.
REQ-010 Port gate_len, input, 16 bits: gate window length in wb_clk_i cycles.
REQ-011 Ports s1, s2, s3, s4, s5, outputs, 1 bit each: oscillator stage selects.
REQ-012 Port start, output, 1 bit: oscillator enable.
REQ-013 Ports X1_Y1, X2_Y1, X3_Y1, X4_Y1, X5_Y1, inputs, 1 bit each: asynchronous oscillator outputs.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 Port count, output, CNT_W bits: rising-edge count from the last completed measurement.
REQ-016 Port count_vld, output, 1 bit: one-cycle pulse marking a new count.
REQ-017 Port ovf, output, 1 bit: set when the last count saturated.

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE, GATE and DONE.
REQ-019 In IDLE, a meas_req with ro_idx <= 4 SHALL latch ro_idx, sel_cfg and gate_len and move to SETTLE on the next clock.
REQ-020 A meas_req with ro_idx > 4 SHALL be ignored.
REQ-021 A meas_req while busy is high SHALL be ignored.
REQ-022 s1..s5 SHALL drive the latched sel_cfg bits 0..4 from SETTLE entry and SHALL hold that value after DONE until the next accepted request.
REQ-023 start SHALL be high exactly in SETTLE and GATE, and low in IDLE and DONE.
REQ-024 SETTLE SHALL last SETTLE_CYC cycles, then the FSM SHALL move to GATE.
REQ-025 The edge counter SHALL clear on GATE entry.
REQ-026 The selected X input SHALL pass through SYNC_STG flops followed by one edge-detect flop.
REQ-027 Each synchronized 0->1 transition seen during GATE SHALL increment the counter.
REQ-028 GATE SHALL last exactly the latched gate_len cycles.
REQ-029 If gate_len = 0, the FSM SHALL go SETTLE -> DONE and report count 0.
REQ-030 The counter SHALL saturate at all-ones and set the ovf flag; it SHALL NOT wrap.
REQ-031 DONE SHALL last one cycle: count and ovf update, count_vld = 1, then the FSM SHALL return to IDLE.
REQ-032 count and ovf SHALL hold until the next DONE.
REQ-033 abort in SETTLE or GATE SHALL return the FSM to IDLE on the next clock, deassert start, and leave count, ovf and count_vld unchanged.
REQ-034 abort and meas_req asserted in the same IDLE cycle SHALL result in abort winning (request dropped).
REQ-035 Measurable input frequency SHALL be below f(wb_clk_i)/2; aliasing above that limit is out of scope.

Reset
REQ-036 While wb_rst_n is low, the block SHALL asynchronously force: state IDLE, s1..s5 = 0, start = 0, busy = 0, count = 0, count_vld = 0, ovf = 0, synchronizer flops = 0.
REQ-037 Reset deassertion SHALL be synchronized externally, and the first accepted request SHALL be the first meas_req after release.
REQ-038 Reset asserted mid-measurement SHALL discard the measurement without producing a count_vld.

Structure
REQ-039 The shared package SHALL hold the FSM state enum, RO_NUM = 5 and the default CNT_W.
REQ-040 The synchronizer plus rising-edge detector SHALL be one sub-module, ro_edge_sync, instantiated once after the ro_idx mux.
REQ-041 The block SHALL NOT use any clock derived from an oscillator output.

Verification
REQ-042 Scenario: ro_idx = 2, sel_cfg = 5'b10101, gate_len = 100, X3_Y1 at f_clk/8 -> count = 12 or 13, count_vld for one cycle, start high for 116 cycles, s = 10101.
REQ-043 Scenario: gate_len = 0 -> count 0, count_vld 17 cycles after meas_req, ovf 0.
REQ-044 Scenario: CNT_W = 4, input at f_clk/4, gate_len = 200 -> count = 4'hF, ovf = 1.
REQ-045 Scenario: abort at cycle 5 of GATE -> start low next cycle, no count_vld, prior count retained.
REQ-046 Scenario: meas_req while busy, and meas_req with ro_idx = 6 -> both ignored, state and latched config unchanged.
REQ-047 Scenario: wb_rst_n pulsed low mid-GATE -> all outputs 0 immediately, no count_vld after release.
